// File: rtl/sensor_query_initiator.sv
// sensor_query_initiator: host-side initiator for the single-byte sensor command
// protocol. It issues "T" (8'h54) or "D" (8'h44) to the UART transmitter. It then
// parses the CR-terminated ASCII-decimal reply fields into binary results.
// Optional feature macro: SQI_RETRY_EN. When defined, the first timeout of a query
// reissues the command instead of raising error 3.
module sensor_query_initiator #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_temp,
    input  logic        req_dist,
    output logic        busy,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  temp_out,
    output logic [7:0]  moist_out,
    output logic [13:0] dist_out,
    output logic        result_valid,
    output logic        error,
    output logic [1:0]  error_code
);

    typedef enum logic [1:0] {IDLE, SEND_CMD, RECV, DONE} state_t;

    localparam logic [7:0]       CMD_T   = 8'h54;
    localparam logic [7:0]       CMD_D   = 8'h44;
    localparam logic [7:0]       CHAR_CR = 8'h0D;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              dist_mode_q, dist_mode_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              field_q, field_d;
    logic [13:0]       acc_q, acc_d;
    logic [2:0]        dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [7:0]        stg_temp_q, stg_temp_d;
    logic [7:0]        temp_q, temp_d;
    logic [7:0]        moist_q, moist_d;
    logic [13:0]       dist_q, dist_d;
    logic              error_q, error_d;
    logic [1:0]        error_code_q, error_code_d;
`ifdef SQI_RETRY_EN
    logic              retry_q, retry_d;
`endif

    // Digit decode and the candidate accumulator value, widened so the range
    // check sees the true value before anything is written back.
    logic        is_digit;
    logic [17:0] acc_ext;
    logic        over;

    // Classify the incoming byte and evaluate the per-field digit/value limits
    always_comb begin
        is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        acc_ext  = ({4'b0, acc_q} * 18'd10) + {14'b0, rx_byte[3:0]};
        if (dist_mode_q) begin
            over = (dcnt_q >= 3'd4) || (acc_ext > 18'd9999);
        end else begin
            over = (dcnt_q >= 3'd3) || (acc_ext > 18'd255);
        end
    end

    // Next-state and datapath update for the query sequencer
    always_comb begin
        state_d      = state_q;
        dist_mode_d  = dist_mode_q;
        cmd_byte_d   = cmd_byte_q;
        field_d      = field_q;
        acc_d        = acc_q;
        dcnt_d       = dcnt_q;
        tcnt_d       = tcnt_q;
        stg_temp_d   = stg_temp_q;
        temp_d       = temp_q;
        moist_d      = moist_q;
        dist_d       = dist_q;
        error_d      = 1'b0;
        error_code_d = error_code_q;
`ifdef SQI_RETRY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            IDLE: begin
                // Received bytes are ignored here; temperature wins a tie.
                if (req_temp || req_dist) begin
                    dist_mode_d = !req_temp;
                    cmd_byte_d  = req_temp ? CMD_T : CMD_D;
                    state_d     = SEND_CMD;
`ifdef SQI_RETRY_EN
                    retry_d     = 1'b0;
`endif
                end
            end
            SEND_CMD: begin
                if (cmd_ready) begin
                    state_d = RECV;
                    field_d = 1'b0;
                    acc_d   = '0;
                    dcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    tcnt_d = '0;
                    if (is_digit) begin
                        if (over) begin
                            state_d      = IDLE;
                            error_d      = 1'b1;
                            error_code_d = 2'd2;
                        end else begin
                            acc_d  = acc_ext[13:0];
                            dcnt_d = dcnt_q + 3'd1;
                        end
                    end else if ((rx_byte == CHAR_CR) && (dcnt_q != 3'd0)) begin
                        if (!dist_mode_q && !field_q) begin
                            stg_temp_d = acc_q[7:0];
                            field_d    = 1'b1;
                            acc_d      = '0;
                            dcnt_d     = '0;
                        end else if (!dist_mode_q) begin
                            // Results load on entry to DONE so they are valid
                            // alongside result_valid.
                            temp_d  = stg_temp_q;
                            moist_d = acc_q[7:0];
                            state_d = DONE;
                        end else begin
                            dist_d  = acc_q;
                            state_d = DONE;
                        end
                    end else begin
                        state_d      = IDLE;
                        error_d      = 1'b1;
                        error_code_d = 2'd1;
                    end
                end else if (tcnt_q == TO_LAST) begin
`ifdef SQI_RETRY_EN
                    if (!retry_q) begin
                        retry_d    = 1'b1;
                        state_d    = SEND_CMD;
                        field_d    = 1'b0;
                        acc_d      = '0;
                        dcnt_d     = '0;
                        stg_temp_d = '0;
                    end else begin
                        state_d      = IDLE;
                        error_d      = 1'b1;
                        error_code_d = 2'd3;
                    end
`else
                    state_d      = IDLE;
                    error_d      = 1'b1;
                    error_code_d = 2'd3;
`endif
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dist_mode_q  <= 1'b0;
            cmd_byte_q   <= '0;
            field_q      <= 1'b0;
            acc_q        <= '0;
            dcnt_q       <= '0;
            tcnt_q       <= '0;
            stg_temp_q   <= '0;
            temp_q       <= '0;
            moist_q      <= '0;
            dist_q       <= '0;
            error_q      <= 1'b0;
            error_code_q <= '0;
`ifdef SQI_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dist_mode_q  <= dist_mode_d;
            cmd_byte_q   <= cmd_byte_d;
            field_q      <= field_d;
            acc_q        <= acc_d;
            dcnt_q       <= dcnt_d;
            tcnt_q       <= tcnt_d;
            stg_temp_q   <= stg_temp_d;
            temp_q       <= temp_d;
            moist_q      <= moist_d;
            dist_q       <= dist_d;
            error_q      <= error_d;
            error_code_q <= error_code_d;
`ifdef SQI_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign busy         = (state_q == SEND_CMD) || (state_q == RECV);
    assign cmd_valid    = (state_q == SEND_CMD);
    assign cmd_byte     = cmd_byte_q;
    assign result_valid = (state_q == DONE);
    assign temp_out     = temp_q;
    assign moist_out    = moist_q;
    assign dist_out     = dist_q;
    assign error        = error_q;
    assign error_code   = error_code_q;

endmodule

// File: tb/tb_sensor_query_initiator.sv
// Testbench for sensor_query_initiator with a short timeout (16 cycles).
// The reply parser is modelled directly from the protocol rules with integers.
module tb_sensor_query_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_temp = 1'b0;
    logic        req_dist = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        busy;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic [7:0]  temp_out;
    logic [7:0]  moist_out;
    logic [13:0] dist_out;
    logic        result_valid;
    logic        error;
    logic [1:0]  error_code;

    int total = 0;
    int bad = 0;
    int exp_temp = 0, exp_moist = 0, exp_dist = 0, exp_code = 0;

    typedef logic [7:0] bq_t[$];

    sensor_query_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .req_temp(req_temp), .req_dist(req_dist),
        .busy(busy), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .temp_out(temp_out),
        .moist_out(moist_out), .dist_out(dist_out), .result_valid(result_valid),
        .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference parser: kind 0 = unterminated, 1 = result, 2 = error.
    task automatic model(input bit t, input bq_t r, output int idx, output int kind,
                         output int code, output int a, output int b);
        int field, acc, n, nv;
        idx = -1; kind = 0; code = 0; a = 0; b = 0;
        field = 0; acc = 0; n = 0;
        for (int i = 0; i < r.size(); i++) begin
            if (r[i] >= 8'h30 && r[i] <= 8'h39) begin
                nv = acc * 10 + int'(r[i] - 8'h30);
                if ((n + 1 > (t ? 3 : 4)) || (nv > (t ? 255 : 9999))) begin
                    kind = 2; code = 2; idx = i; return;
                end
                acc = nv; n++;
            end else if (r[i] == 8'h0D && n > 0) begin
                if (t && field == 0) begin
                    a = acc; field = 1; acc = 0; n = 0;
                end else begin
                    if (t) b = acc; else a = acc;
                    kind = 1; idx = i; return;
                end
            end else begin
                kind = 2; code = 1; idx = i; return;
            end
        end
    endtask

    task automatic push_num(inout bq_t r, input int v, input int minw);
        string s;
        s = $sformatf("%0d", v);
        while (s.len() < minw) s = {"0", s};
        for (int i = 0; i < s.len(); i++) r.push_back(8'(s[i]));
    endtask

    task automatic gen_reply(input bit t, output bq_t r);
        logic [7:0] bads [5];
        int c;
        bads = '{8'h2F, 8'h3A, 8'h41, 8'h20, 8'h0A};
        r = {};
        c = $urandom_range(0, 9);
        case (c)
            0: begin
                push_num(r, $urandom_range(0, 99), $urandom_range(1, 2));
                r.push_back(bads[$urandom_range(0, 4)]);
            end
            1: begin
                if (t && $urandom_range(0, 1) == 1) begin
                    push_num(r, $urandom_range(0, 255), 1);
                    r.push_back(8'h0D);
                end
                r.push_back(8'h0D);
            end
            2: begin
                if (t) begin
                    if ($urandom_range(0, 1) == 1) push_num(r, $urandom_range(256, 999), 3);
                    else push_num(r, $urandom_range(0, 99), 4);
                end else begin
                    push_num(r, $urandom_range(0, 99999), 5);
                end
                r.push_back(8'h0D);
            end
            default: begin
                if (t) begin
                    push_num(r, $urandom_range(0, 255), $urandom_range(1, 3));
                    r.push_back(8'h0D);
                    push_num(r, $urandom_range(0, 255), $urandom_range(1, 3));
                    r.push_back(8'h0D);
                end else begin
                    push_num(r, $urandom_range(0, 9999), $urandom_range(1, 4));
                    r.push_back(8'h0D);
                end
            end
        endcase
    endtask

    // Issue a request, accept the command after 'stall' cycles (-1 = random), feed the
    // reply with random gaps and check the outcome against the reference parser.
    task automatic run_query(input bit t, input bit both, input bq_t r, input int stall);
        int idx, kind, code, a, b, gap;
        bit fin;
        logic [7:0] ecmd;
        model(t, r, idx, kind, code, a, b);
        ecmd = t ? 8'h54 : 8'h44;
        req_temp = t | both;
        req_dist = !t | both;
        rx_valid = 1'($urandom_range(0, 1));
        rx_byte  = 8'h31;
        step();
        req_temp = 0; req_dist = 0; rx_valid = 0;
        total++;
        if ({busy, cmd_valid, cmd_byte} !== {2'b11, ecmd}) begin
            bad++;
            $display("FAIL cmd_issue: busy/valid/byte=%b/%b/%h expected 1/1/%h", busy, cmd_valid, cmd_byte, ecmd);
        end
        if (stall < 0) stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) begin
            cmd_ready = 0;
            step();
            total++;
            if ({cmd_valid, cmd_byte} !== {1'b1, ecmd}) begin
                bad++;
                $display("FAIL cmd_hold: valid/byte=%b/%h expected 1/%h", cmd_valid, cmd_byte, ecmd);
            end
        end
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        total++;
        if ({busy, cmd_valid} !== 2'b10) begin
            bad++;
            $display("FAIL cmd_accept: busy/valid=%b/%b expected 1/0", busy, cmd_valid);
        end
        fin = 0;
        for (int i = 0; i < r.size() && !fin; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                req_dist = ($urandom_range(0, 7) == 0);
                rx_byte = 8'($urandom);
                step();
                req_dist = 0;
                total++;
                if ({result_valid, error, busy} !== 3'b001) begin
                    bad++;
                    $display("FAIL idle_gap: rv/err/busy=%b%b%b expected 001", result_valid, error, busy);
                end
            end
            rx_valid = 1;
            rx_byte = r[i];
            step();
            rx_valid = 0;
            total++;
            if (i == idx) begin
                fin = 1;
                if (kind == 1) begin
                    if (t) begin exp_temp = a; exp_moist = b; end
                    else exp_dist = a;
                    if ({result_valid, error, busy} !== 3'b100) begin
                        bad++;
                        $display("FAIL result_pulse: rv/err/busy=%b%b%b expected 100", result_valid, error, busy);
                    end
                end else begin
                    exp_code = code;
                    if ({result_valid, error, busy, error_code} !== {3'b010, 2'(code)}) begin
                        bad++;
                        $display("FAIL error_pulse: rv/err/busy/code=%b%b%b/%0d expected 010/%0d",
                                 result_valid, error, busy, error_code, code);
                    end
                end
                total++;
                if ({temp_out, moist_out, dist_out} !== {8'(exp_temp), 8'(exp_moist), 14'(exp_dist)}) begin
                    bad++;
                    $display("FAIL outputs: temp/moist/dist=%0d/%0d/%0d expected %0d/%0d/%0d",
                             temp_out, moist_out, dist_out, exp_temp, exp_moist, exp_dist);
                end
            end else if ({result_valid, error, busy} !== 3'b001) begin
                bad++;
                $display("FAIL mid_reply: rv/err/busy=%b%b%b expected 001", result_valid, error, busy);
            end
        end
        step();
        total++;
        if ({result_valid, error, busy, error_code} !== {3'b000, 2'(exp_code)}) begin
            bad++;
            $display("FAIL after_query: rv/err/busy/code=%b%b%b/%0d expected 000/%0d",
                     result_valid, error, busy, error_code, exp_code);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({busy, cmd_valid, cmd_byte, temp_out, moist_out, dist_out, result_valid, error, error_code} !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b cv=%b cb=%h t=%0d m=%0d d=%0d rv=%b e=%b ec=%0d expected all 0",
                     busy, cmd_valid, cmd_byte, temp_out, moist_out, dist_out, result_valid, error, error_code);
        end
        rst = 0;
        step();
    endtask

    task automatic test_temp_basic();
        bq_t r;
        r = {8'h30, 8'h32, 8'h35, 8'h0D, 8'h30, 8'h36, 8'h33, 8'h0D};
        run_query(1, 0, r, 0);
        total++;
        if ({temp_out, moist_out, dist_out} !== {8'd25, 8'd63, 14'd0}) begin
            bad++;
            $display("FAIL temp_basic: temp/moist/dist=%0d/%0d/%0d expected 25/63/0", temp_out, moist_out, dist_out);
        end
    endtask

    task automatic test_dist_stall();
        bq_t r;
        r = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
        run_query(0, 0, r, 5);
        total++;
        if ({temp_out, moist_out, dist_out} !== {8'd25, 8'd63, 14'd1234}) begin
            bad++;
            $display("FAIL dist_stall: temp/moist/dist=%0d/%0d/%0d expected 25/63/1234", temp_out, moist_out, dist_out);
        end
    endtask

    task automatic test_overflow();
        bq_t r;
        r = {8'h32, 8'h35, 8'h36, 8'h0D};
        run_query(1, 0, r, 1);
        total++;
        if ({error_code, temp_out} !== {2'd2, 8'd25}) begin
            bad++;
            $display("FAIL temp_overflow: code/temp=%0d/%0d expected 2/25", error_code, temp_out);
        end
        r = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        run_query(0, 0, r, 0);
        total++;
        if ({error_code, dist_out} !== {2'd2, 14'd1234}) begin
            bad++;
            $display("FAIL dist_overflow: code/dist=%0d/%0d expected 2/1234", error_code, dist_out);
        end
    endtask

    task automatic test_bad_char();
        bq_t r;
        r = {8'h32, 8'h41};
        run_query(1, 0, r, 0);
        total++;
        if (error_code !== 2'd1) begin
            bad++;
            $display("FAIL bad_char: code=%0d expected 1", error_code);
        end
        r = {8'h0D};
        run_query(0, 0, r, 0);
        total++;
        if (error_code !== 2'd1) begin
            bad++;
            $display("FAIL empty_field: code=%0d expected 1", error_code);
        end
    endtask

    task automatic test_both_requests();
        bq_t r;
        r = {8'h37, 8'h0D, 8'h39, 8'h39, 8'h0D};
        run_query(1, 1, r, 2);
        total++;
        if ({temp_out, moist_out} !== {8'd7, 8'd99}) begin
            bad++;
            $display("FAIL both_requests: temp/moist=%0d/%0d expected 7/99", temp_out, moist_out);
        end
    endtask

    // Silence after acceptance: error (or retry) exactly TO cycles later.
    task automatic test_timeout();
        int rounds;
        req_temp = 1;
        step();
        req_temp = 0;
        cmd_ready = 1;
        step();
        cmd_ready = 0;
`ifdef SQI_RETRY_EN
        rounds = 2;
`else
        rounds = 1;
`endif
        for (int rnd = 0; rnd < rounds; rnd++) begin
            for (int c = 1; c < TO; c++) begin
                step();
                total++;
                if ({error, busy} !== 2'b01) begin
                    bad++;
                    $display("FAIL timeout_early: cycle %0d err/busy=%b%b expected 01", c, error, busy);
                end
            end
            step();
            total++;
            if (rnd + 1 < rounds) begin
                if ({error, busy, cmd_valid, cmd_byte} !== {3'b011, 8'h54}) begin
                    bad++;
                    $display("FAIL timeout_retry: err/busy/cv/cb=%b%b%b/%h expected 011/54", error, busy, cmd_valid, cmd_byte);
                end
                cmd_ready = 1;
                step();
                cmd_ready = 0;
            end else begin
                exp_code = 3;
                if ({error, busy, error_code} !== {2'b10, 2'd3}) begin
                    bad++;
                    $display("FAIL timeout_error: err/busy/code=%b%b/%0d expected 10/3", error, busy, error_code);
                end
            end
        end
        step();
        total++;
        if ({error, busy, temp_out, moist_out} !== {2'b00, 8'(exp_temp), 8'(exp_moist)}) begin
            bad++;
            $display("FAIL timeout_after: err/busy/temp/moist=%b%b/%0d/%0d expected 00/%0d/%0d",
                     error, busy, temp_out, moist_out, exp_temp, exp_moist);
        end
    endtask

    // A byte landing on the last allowed cycle is processed and restarts the count.
    task automatic test_timeout_edge();
        logic [7:0] seq [4];
        seq = '{8'h37, 8'h0D, 8'h38, 8'h0D};
        req_temp = 1;
        step();
        req_temp = 0;
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < TO - 1; c++) step();
            rx_valid = 1;
            rx_byte = seq[s];
            step();
            rx_valid = 0;
            total++;
            if (s < 3) begin
                if ({error, busy, result_valid} !== 3'b010) begin
                    bad++;
                    $display("FAIL edge_byte%0d: err/busy/rv=%b%b%b expected 010", s, error, busy, result_valid);
                end
            end else begin
                exp_temp = 7; exp_moist = 8;
                if ({error, result_valid, temp_out, moist_out} !== {2'b01, 8'd7, 8'd8}) begin
                    bad++;
                    $display("FAIL edge_result: err/rv/temp/moist=%b%b/%0d/%0d expected 01/7/8",
                             error, result_valid, temp_out, moist_out);
                end
            end
        end
        step();
    endtask

    task automatic test_random();
        bq_t r;
        bit t;
        for (int n = 0; n < 40; n++) begin
            t = 1'($urandom_range(0, 1));
            gen_reply(t, r);
            run_query(t, 0, r, -1);
        end
    endtask

    task automatic test_reset_mid_recv();
        req_dist = 1;
        step();
        req_dist = 0;
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        rx_valid = 1;
        rx_byte = 8'h35;
        step();
        rx_valid = 0;
        #2;
        rst = 1;
        #1;
        total++;
        if ({busy, cmd_valid, cmd_byte, temp_out, moist_out, dist_out, result_valid, error, error_code} !== '0) begin
            bad++;
            $display("FAIL reset_mid_recv: busy=%b cv=%b cb=%h t=%0d m=%0d d=%0d rv=%b e=%b ec=%0d expected all 0",
                     busy, cmd_valid, cmd_byte, temp_out, moist_out, dist_out, result_valid, error, error_code);
        end
        step();
        step();
        rst = 0;
        exp_temp = 0; exp_moist = 0; exp_dist = 0; exp_code = 0;
        for (int c = 0; c < TO + 4; c++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_byte = 8'h0D;
            step();
            total++;
            if ({result_valid, error, busy, error_code} !== 5'b0) begin
                bad++;
                $display("FAIL post_reset: rv/err/busy/code=%b%b%b/%0d expected 000/0", result_valid, error, busy, error_code);
            end
        end
        rx_valid = 0;
    endtask

    initial begin
        test_reset();
        test_temp_basic();
        test_dist_stall();
        test_overflow();
        test_bad_char();
        test_both_requests();
        test_timeout();
        test_timeout_edge();
        test_random();
        test_reset_mid_recv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
